// File: rtl/mux4to1_scanner.sv
// Scans an external CHANNELS-to-1 mux one select slot at a time.
// Each completed frame is published on a_out in a single update.
module mux4to1_scanner #(
   parameter int CHANNELS    = 4,
   parameter int SEL_W       = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                cont,
   input  logic                y_in,
   output logic [SEL_W-1:0]    sel_out,
   output logic [CHANNELS-1:0] a_out,
   output logic                done,
   output logic                busy
);

   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(CHANNELS - 1);
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

   logic [0:0]          state;
   logic [HC_W-1:0]     hold_cnt;
   logic [CHANNELS-1:0] shadow;
   logic [CHANNELS-1:0] shadow_upd;

   // Shadow word as it will look once the current slot's sample lands.
   always_comb begin
      shadow_upd = shadow;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_out == SEL_W'(i)) begin
            shadow_upd[i] = y_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel_out  <= '0;
         hold_cnt <= '0;
         shadow   <= '0;
         a_out    <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sel_out  <= '0;
               hold_cnt <= '0;
               if (start) begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  hold_cnt <= '0;
                  shadow   <= shadow_upd;
                  if (sel_out != LAST_SEL) begin
                     sel_out <= sel_out + 1'b1;
                  end else begin
                     // Final slot: publish the whole frame at once.
                     a_out   <= shadow_upd;
                     done    <= 1'b1;
                     sel_out <= '0;
                     if (!cont) begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SCAN);

endmodule
